// File: rtl/ram_port_sequencer.sv
// Round-robin write/read arbiter and full-clear sequencer for port 0 of the character RAM.
// Latency from grant: wr_ack in cycle 1, rd_valid in cycle 3; requesters are held by level req until ack/valid.
module ram_port_sequencer #(
  parameter int                    DATA_WIDTH  = 7,
  parameter int                    ADDR_WIDTH  = 12,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = 7'h20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_req,
  output logic                  clear_busy,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe
);

  typedef enum logic [2:0] {IDLE, WRITE, RD_ADDR, RD_DATA, RD_DONE, CLEAR} state_t;

  state_t                state, state_d;
  logic                  last_rd, last_rd_d;
  logic                  clear_pend, clear_pend_d;
  logic                  clear_busy_d;
  logic                  cs_d, we_d, oe_d, wr_ack_d, rd_valid_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata, wdata_d;
  logic [DATA_WIDTH-1:0] rd_data_d;

  // The write word only reaches the bus while a write strobe is registered.
  assign ram_data = (ram_cs && ram_we) ? wdata : {DATA_WIDTH{1'bz}};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_rd    <= 1'b1;
      clear_pend <= 1'b0;
      clear_busy <= 1'b0;
      ram_cs     <= 1'b0;
      ram_we     <= 1'b0;
      ram_oe     <= 1'b0;
      ram_addr   <= '0;
      wdata      <= '0;
      wr_ack     <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
    end else begin
      state      <= state_d;
      last_rd    <= last_rd_d;
      clear_pend <= clear_pend_d;
      clear_busy <= clear_busy_d;
      ram_cs     <= cs_d;
      ram_we     <= we_d;
      ram_oe     <= oe_d;
      ram_addr   <= addr_d;
      wdata      <= wdata_d;
      wr_ack     <= wr_ack_d;
      rd_valid   <= rd_valid_d;
      rd_data    <= rd_data_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (clear_pend)
          state_d = CLEAR;
        else if (wr_req && rd_req)
          state_d = last_rd ? WRITE : RD_ADDR;
        else if (wr_req)
          state_d = WRITE;
        else if (rd_req)
          state_d = RD_ADDR;
      end
      WRITE:   state_d = IDLE;
      RD_ADDR: state_d = RD_DATA;
      RD_DATA: state_d = RD_DONE;
      RD_DONE: state_d = IDLE;
      CLEAR:   state_d = (&ram_addr) ? IDLE : CLEAR;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs are computed from the state being entered.
  always_comb begin
    cs_d       = 1'b0;
    we_d       = 1'b0;
    oe_d       = 1'b0;
    wr_ack_d   = 1'b0;
    rd_valid_d = 1'b0;
    addr_d     = ram_addr;
    wdata_d    = wdata;
    rd_data_d  = rd_data;
    last_rd_d  = last_rd;
    case (state_d)
      WRITE: begin
        cs_d      = 1'b1;
        we_d      = 1'b1;
        wr_ack_d  = 1'b1;
        addr_d    = wr_addr;
        wdata_d   = wr_data;
        last_rd_d = 1'b0;
      end
      RD_ADDR: begin
        cs_d      = 1'b1;
        oe_d      = 1'b1;
        addr_d    = rd_addr;
        last_rd_d = 1'b1;
      end
      RD_DATA: begin
        cs_d = 1'b1;
        oe_d = 1'b1;
      end
      RD_DONE: begin
        rd_valid_d = 1'b1;
        rd_data_d  = ram_data;
      end
      CLEAR: begin
        cs_d    = 1'b1;
        we_d    = 1'b1;
        wdata_d = CLEAR_VALUE;
        addr_d  = (state == CLEAR) ? ram_addr + ADDR_WIDTH'(1) : '0;
      end
      default: ;
    endcase

    clear_pend_d = clear_pend;
    if (state == IDLE && state_d == CLEAR)
      clear_pend_d = 1'b0;
    else if (clear_req && !clear_busy)
      clear_pend_d = 1'b1;

    clear_busy_d = clear_busy;
    if (clear_req && !clear_busy)
      clear_busy_d = 1'b1;
    else if (state == CLEAR && state_d == IDLE)
      clear_busy_d = 1'b0;
  end

endmodule

// File: tb/tb_ram_port_sequencer.sv
// Directed bench for ram_port_sequencer with a behavioural port-0 RAM model.
module tb_ram_port_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear_req;
  logic        clear_busy;
  logic        wr_req;
  logic [11:0] wr_addr;
  logic [6:0]  wr_data;
  logic        wr_ack;
  logic        rd_req;
  logic [11:0] rd_addr;
  logic [6:0]  rd_data;
  logic        rd_valid;
  logic [11:0] ram_addr;
  wire  [6:0]  ram_data;
  logic        ram_cs;
  logic        ram_we;
  logic        ram_oe;

  int total = 0;
  int bad = 0;

  ram_port_sequencer #(.DATA_WIDTH(7), .ADDR_WIDTH(12), .CLEAR_VALUE(7'h20)) dut (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .clear_busy(clear_busy),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_cs(ram_cs), .ram_we(ram_we),
    .ram_oe(ram_oe)
  );

  always #5 clk = ~clk;

  // RAM port 0: registered read, drives the bus in the cycle after the address cycle.
  logic [6:0] mem [4096];
  logic [6:0] rq = 7'h00;
  logic       drv = 1'b0;
  int         wcnt = 0;
  assign ram_data = drv ? rq : 7'bz;
  always @(posedge clk) begin
    if (ram_cs && ram_we) begin
      mem[ram_addr] <= ram_data;
      wcnt <= wcnt + 1;
    end
    drv <= ram_cs && ram_oe && !ram_we;
    rq  <= mem[ram_addr];
  end

  int bus_viol = 0;
  always @(negedge clk) begin
    if ((ram_we && ram_oe) || (wr_ack && rd_valid))
      bus_viol <= bus_viol + 1;
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [11:0] a, input logic [6:0] d, input string tag);
    int n;
    wr_req = 1'b1; wr_addr = a; wr_data = d; n = 0;
    do begin tick(); n++; end while (!wr_ack && n < 20);
    wr_req = 1'b0;
    chk(tag, n, 1);
    tick();
  endtask

  task automatic do_read(input logic [11:0] a, input logic [6:0] exp, input string tag);
    int n;
    rd_req = 1'b1; rd_addr = a; n = 0;
    do begin tick(); n++; end while (!rd_valid && n < 20);
    rd_req = 1'b0;
    chk({tag, "_lat"}, n, 3);
    chk(tag, rd_data, exp);
    tick();
  endtask

  initial begin
    int n, cnt, early, w0, found;
    logic ev [8];
    logic [6:0] first_rd;

    rst_n = 1'b0; clear_req = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    tick(); tick();
    chk("rst_cs", ram_cs, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_oe", ram_oe, 0);
    chk("rst_wr_ack", wr_ack, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_busy", clear_busy, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_rd_data", rd_data, 0);
    rst_n = 1'b1;

    // Single write then readback
    wr_req = 1'b1; wr_addr = 12'h005; wr_data = 7'h41;
    tick();
    chk("w1_cs", ram_cs, 1);
    chk("w1_we", ram_we, 1);
    chk("w1_oe", ram_oe, 0);
    chk("w1_addr", ram_addr, 12'h005);
    chk("w1_bus", ram_data, 7'h41);
    chk("w1_ack", wr_ack, 1);
    wr_req = 1'b0;
    tick();
    chk("w1_ack_one_cycle", wr_ack, 0);
    rd_req = 1'b1; rd_addr = 12'h005;
    tick();
    chk("r1_c1_cs_oe", {ram_cs, ram_oe, ram_we}, 3'b110);
    chk("r1_c1_valid", rd_valid, 0);
    tick();
    chk("r1_c2_valid", rd_valid, 0);
    tick();
    chk("r1_c3_valid", rd_valid, 1);
    chk("r1_data", rd_data, 7'h41);
    rd_req = 1'b0;
    tick();
    chk("r1_valid_one_cycle", rd_valid, 0);
    chk("r1_strobes_off", {ram_cs, ram_oe, ram_we}, 3'b000);

    // Both requesters held from reset: W,R,W,R
    rst_n = 1'b0; tick(); tick();
    rst_n = 1'b1;
    wr_req = 1'b1; wr_addr = 12'h010; wr_data = 7'h55;
    rd_req = 1'b1; rd_addr = 12'h010;
    n = 0; first_rd = 7'h7f;
    for (int c = 0; c < 26; c++) begin
      tick();
      if (wr_ack && n < 8) begin ev[n] = 1'b0; n++; end
      if (rd_valid && n < 8) begin
        if (first_rd == 7'h7f) first_rd = rd_data;
        ev[n] = 1'b1; n++;
      end
    end
    wr_req = 1'b0; rd_req = 1'b0;
    chk("rr_event_count", n >= 4, 1);
    chk("rr_order", {ev[0], ev[1], ev[2], ev[3]}, 4'b0101);
    chk("rr_read_data", first_rd, 7'h55);
    repeat (6) tick();

    // Full clear with a write parked mid-clear
    w0 = wcnt;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    chk("clr_busy_next", clear_busy, 1);
    cnt = 0; early = 0;
    while (clear_busy && cnt < 6000) begin
      cnt++;
      if (cnt == 100) begin wr_req = 1'b1; wr_addr = 12'h123; wr_data = 7'h33; end
      if (wr_ack) early++;
      tick();
    end
    chk("clr_busy_cycles", cnt, 4097);
    chk("clr_write_count", wcnt - w0, 4096);
    chk("clr_no_early_ack", early, 0);
    tick();
    chk("clr_wr_after", wr_ack, 1);
    wr_req = 1'b0;
    tick();
    do_read(12'h000, 7'h20, "clr_rd_000");
    do_read(12'h7FF, 7'h20, "clr_rd_7ff");
    do_read(12'hFFF, 7'h20, "clr_rd_fff");
    do_read(12'h005, 7'h20, "clr_rd_005");
    do_read(12'h123, 7'h33, "clr_rd_123");

    // clear_req during RD_DATA, second clear_req while busy
    rd_req = 1'b1; rd_addr = 12'h123;
    tick();
    chk("cr_rdaddr", ram_addr, 12'h123);
    tick();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    rd_req = 1'b0;
    chk("cr_rd_valid", rd_valid, 1);
    chk("cr_rd_data", rd_data, 7'h33);
    chk("cr_busy", clear_busy, 1);
    w0 = wcnt; cnt = 0;
    while (clear_busy && cnt < 6000) begin
      cnt++;
      clear_req = (cnt == 50);
      tick();
    end
    clear_req = 1'b0;
    chk("cr_busy_cycles", cnt, 4098);
    chk("cr_write_count", wcnt - w0, 4096);
    do_read(12'h123, 7'h20, "cr_rd_123");

    // Reset during RD_DATA
    do_write(12'h301, 7'h5A, "rs_wr_301");
    rd_req = 1'b1; rd_addr = 12'h301;
    tick(); tick();
    rst_n = 1'b0; rd_req = 1'b0;
    tick();
    chk("rs_rd_strobes", {ram_cs, ram_we, ram_oe}, 3'b000);
    chk("rs_rd_valid", rd_valid, 0);
    rst_n = 1'b1;
    tick();
    chk("rs_rd_no_valid", rd_valid, 0);
    tick();

    // Reset during CLEAR at 0x300
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    n = 0; found = 0;
    while (n < 5000 && found == 0) begin
      if (ram_cs && ram_we && ram_addr == 12'h300) found = 1;
      else begin tick(); n++; end
    end
    chk("rs_clr_reach_300", found, 1);
    rst_n = 1'b0;
    tick();
    chk("rs_clr_strobes", {ram_cs, ram_we, ram_oe}, 3'b000);
    chk("rs_clr_busy", clear_busy, 0);
    chk("rs_clr_addr", ram_addr, 0);
    rst_n = 1'b1;
    tick();
    do_read(12'h301, 7'h5A, "rs_rd_301");
    do_read(12'h2FF, 7'h20, "rs_rd_2ff");

    chk("bus_rules", bus_viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_port_sequencer.md
Name: ram_port_sequencer

Overview:
- Owns port 0 of the 7-bit x 4096 dual-port character RAM. Port 1 is left to the display scan.
- Arbitrates between a write requester (host/keyboard path) and a read requester (cursor/readback path) on a round-robin basis.
- Runs a full-memory clear sequence on command.
- Generates all cs/we/oe strobes and handles the tri-state data bus, so requesters see a simple req/ack interface.

Parameters:
DATA_WIDTH, 7, RAM word width
ADDR_WIDTH, 12, RAM address width; depth = 2**ADDR_WIDTH
CLEAR_VALUE, 7'h20, word written to every location during clear (ASCII space)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
clear_req  in  1  single-cycle pulse: start full-memory clear
clear_busy  out  1  high while clear is pending or running
wr_req  in  1  write request; level, held until wr_ack
wr_addr  in  ADDR_WIDTH  write address, stable while wr_req high
wr_data  in  DATA_WIDTH  write data, stable while wr_req high
wr_ack  out  1  one-cycle pulse: write performed
rd_req  in  1  read request; level, held until rd_valid
rd_addr  in  ADDR_WIDTH  read address, stable while rd_req high
rd_data  out  DATA_WIDTH  read result, held until the next read completes
rd_valid  out  1  one-cycle pulse: rd_data updated
ram_addr  out  ADDR_WIDTH  to RAM address_0
ram_data  inout  DATA_WIDTH  to RAM data_0
ram_cs  out  1  to RAM cs_0
ram_we  out  1  to RAM we_0
ram_oe  out  1  to RAM oe_0

Behaviour:
- Interface facts:
  - One clock domain. Reset is synchronous and active-low.
  - All outputs except ram_data are registered.
  - ram_data is driven with the write word only when ram_cs=1 and ram_we=1; otherwise it is high-Z.
- Reset (rst_n=0 at an edge), including mid-operation:
  - ram_cs, ram_we, ram_oe, wr_ack, rd_valid, clear_busy = 0; ram_addr = 0; rd_data = 0; ram_data released.
  - FSM goes to IDLE, clear counter = 0, pending clear dropped, last_grant = READ.
  - An in-flight write or read is abandoned with no ack or valid.
- FSM states: IDLE, WRITE, RD_ADDR, RD_DATA, RD_DONE, CLEAR.
- IDLE: strobes low. Priority at each edge:
  - clear_pend set -> CLEAR, with ram_addr=0, cs=1, we=1.
  - Else if wr_req and rd_req are both high, grant the requester opposite to last_grant.
  - Else grant whichever single request is high.
  - A grant latches the address/data and updates last_grant.
- WRITE, 1 cycle:
  - Outputs ram_cs=1, ram_we=1, ram_oe=0, ram_addr=wr_addr; ram_data driven with wr_data; wr_ack=1.
  - The RAM writes at the closing edge; FSM then goes to IDLE.
  - The requester must drop wr_req at that edge; if it is still high in IDLE, that is a new request.
- RD_ADDR, 1 cycle: ram_cs=1, ram_oe=1, ram_we=0, ram_addr=rd_addr. The RAM registers the word at the closing edge.
- RD_DATA, 1 cycle: strobes held; the RAM drives ram_data. The controller samples ram_data into rd_data at the closing edge.
- RD_DONE, 1 cycle: strobes low, rd_valid=1, then IDLE. The requester drops rd_req at that edge.
- Latency, counted from the grant edge:
  - wr_ack is high in cycle 1.
  - rd_valid is high in cycle 3.
  - Minimum one IDLE cycle between transactions, so write throughput is 1 per 2 cycles and read throughput 1 per 4 cycles.
- Clear sequence:
  - clear_req while clear_busy=0 sets clear_pend and clear_busy from the next cycle. clear_req while busy is ignored.
  - An ongoing write or read completes first; clear starts at the next IDLE.
  - CLEAR writes CLEAR_VALUE to address 0..2**ADDR_WIDTH-1, one per cycle, incrementing ram_addr with cs=we=1.
  - After the write to the last address the FSM goes to IDLE and clear_busy falls in that same IDLE cycle.
  - No wrap: exactly 2**ADDR_WIDTH writes.
  - wr_req/rd_req stay pending during clear without ack, and are served afterwards.
- Simultaneous events:
  - clear_req arriving with a grant in the same IDLE cycle: the grant proceeds and clear follows.
  - wr_req and rd_req rising together right after reset: WRITE wins first.
- The block never asserts ram_we and ram_oe together and never drives ram_data while ram_we=0.

Test Plan:
- Reset then write: wr_req, wr_addr=12'h005, wr_data=7'h41 -> next cycle ram_cs=1, ram_we=1, ram_data=7'h41, wr_ack=1 for exactly 1 cycle. A later read of 12'h005 gives rd_data=7'h41, with rd_valid exactly 3 cycles after the grant edge.
- Both requesters held continuously (write 12'h010, read 12'h010) -> grants alternate W,R,W,R. First grant is W. wr_ack and rd_valid never assert in the same cycle.
- clear_req pulse with CLEAR_VALUE=7'h20 -> clear_busy high for 1+4096 cycles (pending, then 4096 writes). Reads of 12'h000, 12'h7FF, 12'hFFF return 7'h20. A wr_req issued mid-clear is acked only after clear_busy falls.
- clear_req during RD_DATA -> the read completes with a correct rd_valid, then CLEAR starts. A second clear_req while busy causes no restart (total write count 4096).
- rst_n=0 during RD_DATA and during CLEAR at address 12'h300 -> next cycle all strobes 0, ram_data high-Z, no rd_valid. After release, 12'h301 still holds its old value.
- Bus checker on every cycle: ram_we&ram_oe never 1. ram_data is non-Z from the sequencer only when ram_cs&ram_we.
